// File: rtl/fd_eq_pkg.sv
// Shared constants and the coefficient type for the 512-bin frequency-domain equaliser.
// Frame geometry is fixed here; datapath widths are parameters on the modules.
package fd_eq_pkg;

  localparam int NFFT     = 512;
  localparam int NBEAT    = 8;
  localparam int NS_IN    = NFFT / NBEAT;
  localparam int CFG_AW   = $clog2(NFFT);
  localparam int BEAT_W   = $clog2(NBEAT);
  localparam int LANE_W   = $clog2(NS_IN);

  localparam int NBW_COEF = 10;
  localparam int NBI_COEF = 2;

  typedef struct packed {
    logic signed [NBW_COEF-1:0] re;
    logic signed [NBW_COEF-1:0] im;
  } coef_t;

  // 1.0 + j0 in the coefficient format
  localparam coef_t COEF_UNITY = '{re: NBW_COEF'(1 << (NBW_COEF - NBI_COEF)), im: '0};

  function automatic coef_t make_coef(input logic [NBW_COEF-1:0] re,
                                      input logic [NBW_COEF-1:0] im);
    coef_t c;
    c.re = re;
    c.im = im;
    return c;
  endfunction

endpackage

// File: rtl/cmult_rnd_sat.sv
// One-lane complex multiply: registered partial products, then combine, round half-up
// and symmetric saturation into a registered output. Two cycles from operands to output.
module cmult_rnd_sat
  import fd_eq_pkg::*;
#(
  parameter int NBW_IN  = 11,
  parameter int NBI_IN  = 11,
  parameter int NBW_OUT = 11,
  parameter int NBI_OUT = 11
) (
  input  logic                clk,
  input  logic                rst_async_n,
  input  logic [NBW_IN-1:0]   a_re,
  input  logic [NBW_IN-1:0]   a_im,
  input  logic [NBW_COEF-1:0] c_re,
  input  logic [NBW_COEF-1:0] c_im,
  output logic [NBW_OUT-1:0]  y_re,
  output logic [NBW_OUT-1:0]  y_im
);

  localparam int PW     = NBW_IN + NBW_COEF;
  // one bit for the add/sub, one more so the rounding constant cannot wrap
  localparam int SW     = PW + 2;
  localparam int FRAC_P = (NBW_IN - NBI_IN) + (NBW_COEF - NBI_COEF);
  localparam int FRAC_O = NBW_OUT - NBI_OUT;
  localparam int SH     = FRAC_P - FRAC_O;

  localparam logic signed [SW-1:0] RND  = SW'(1 << (SH - 1));
  localparam logic signed [SW-1:0] MAXV = SW'((1 << (NBW_OUT - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = -MAXV;

  logic signed [PW-1:0] ac_reg, bd_reg, ad_reg, bc_reg;
  logic signed [SW-1:0] re_sum, im_sum, re_sh, im_sh;

  function automatic logic [NBW_OUT-1:0] sat(input logic signed [SW-1:0] v);
    if (v > MAXV)
      return MAXV[NBW_OUT-1:0];
    else if (v < MINV)
      return MINV[NBW_OUT-1:0];
    else
      return v[NBW_OUT-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      ac_reg <= '0;
      bd_reg <= '0;
      ad_reg <= '0;
      bc_reg <= '0;
    end else begin
      ac_reg <= PW'($signed(a_re)) * PW'($signed(c_re));
      bd_reg <= PW'($signed(a_im)) * PW'($signed(c_im));
      ad_reg <= PW'($signed(a_re)) * PW'($signed(c_im));
      bc_reg <= PW'($signed(a_im)) * PW'($signed(c_re));
    end
  end

  always_comb begin
    re_sum = SW'(ac_reg) - SW'(bd_reg) + RND;
    im_sum = SW'(ad_reg) + SW'(bc_reg) + RND;
    re_sh  = re_sum >>> SH;
    im_sh  = im_sum >>> SH;
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      y_re <= '0;
      y_im <= '0;
    end else begin
      y_re <= sat(re_sh);
      y_im <= sat(im_sh);
    end
  end

endmodule

// File: rtl/fd_eq512_coef_mult.sv
// Per-bin complex equaliser after the 512-pt FFT: 64 lanes x 8 beats, double-buffered
// coefficients swapped only at a frame boundary, round/saturate, fixed 3-cycle latency.
module fd_eq512_coef_mult
  import fd_eq_pkg::*;
#(
  parameter int NBW_IN  = 11,
  parameter int NBI_IN  = 11,
  parameter int NBW_OUT = 11,
  parameter int NBI_OUT = 11
) (
  input  logic                      clk,
  input  logic                      rst_async_n,
  input  logic                      i_valid,
  input  logic [NS_IN*NBW_IN-1:0]   i_data_i,
  input  logic [NS_IN*NBW_IN-1:0]   i_data_q,
  input  logic                      i_bypass,
  input  logic                      i_cfg_we,
  input  logic [CFG_AW-1:0]         i_cfg_addr,
  input  logic [NBW_COEF-1:0]       i_cfg_coef_i,
  input  logic [NBW_COEF-1:0]       i_cfg_coef_q,
  input  logic                      i_cfg_commit,
  output logic                      o_cfg_busy,
  output logic                      o_coef_loaded,
  output logic                      o_valid,
  output logic [BEAT_W-1:0]         o_beat,
  output logic [NS_IN*NBW_OUT-1:0]  o_data_i,
  output logic [NS_IN*NBW_OUT-1:0]  o_data_q
);

  logic [BEAT_W-1:0] cnt_reg;
  logic              busy_reg;
  logic              loaded_reg;
  logic              bank_sel_reg;

  logic              swap_now;
  logic              cfg_wr;
  logic [LANE_W-1:0] wr_lane;
  logic [BEAT_W-1:0] wr_beat;
  coef_t             wr_coef;

  logic                     v1_reg, v2_reg;
  logic [BEAT_W-1:0]        beat1_reg, beat2_reg;
  logic                     unity1_reg;
  logic                     use_b1_reg;
  logic [NS_IN*NBW_IN-1:0]  d_i1_reg, d_q1_reg;

  // The beat that carries out the swap already reads the incoming bank.
  assign swap_now = i_valid && busy_reg && (cnt_reg == '0);
  assign cfg_wr   = i_cfg_we && !busy_reg;
  assign wr_lane  = i_cfg_addr[LANE_W-1:0];
  assign wr_beat  = i_cfg_addr[CFG_AW-1:LANE_W];
  assign wr_coef  = make_coef(i_cfg_coef_i, i_cfg_coef_q);

  assign o_cfg_busy    = busy_reg;
  assign o_coef_loaded = loaded_reg;

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      cnt_reg      <= '0;
      busy_reg     <= 1'b0;
      loaded_reg   <= 1'b0;
      bank_sel_reg <= 1'b0;
    end else begin
      if (i_valid)
        cnt_reg <= (cnt_reg == BEAT_W'(NBEAT - 1)) ? '0 : cnt_reg + 1'b1;
      // a commit arriving while busy (including the swap cycle) is absorbed
      if (swap_now) begin
        busy_reg     <= 1'b0;
        loaded_reg   <= 1'b1;
        bank_sel_reg <= ~bank_sel_reg;
      end else if (i_cfg_commit) begin
        busy_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      v1_reg     <= 1'b0;
      beat1_reg  <= '0;
      unity1_reg <= 1'b1;
      use_b1_reg <= 1'b0;
      d_i1_reg   <= '0;
      d_q1_reg   <= '0;
      v2_reg     <= 1'b0;
      beat2_reg  <= '0;
      o_valid    <= 1'b0;
      o_beat     <= '0;
    end else begin
      v1_reg     <= i_valid;
      beat1_reg  <= cnt_reg;
      unity1_reg <= i_bypass || !(loaded_reg || swap_now);
      use_b1_reg <= swap_now ? !bank_sel_reg : bank_sel_reg;
      d_i1_reg   <= i_data_i;
      d_q1_reg   <= i_data_q;
      v2_reg     <= v1_reg;
      beat2_reg  <= beat1_reg;
      o_valid    <= v2_reg;
      o_beat     <= beat2_reg;
    end
  end

  for (genvar gi = 0; gi < NS_IN; gi++) begin : g_lane
    coef_t mem_a [NBEAT];
    coef_t mem_b [NBEAT];
    coef_t rd_a_reg;
    coef_t rd_b_reg;
    coef_t coef_sel;
    logic  wr_hit;

    assign wr_hit = cfg_wr && (wr_lane == LANE_W'(gi));

    // bank_sel_reg names the active bank; writes always go to the other one
    always_ff @(posedge clk) begin
      if (wr_hit && bank_sel_reg)
        mem_a[wr_beat] <= wr_coef;
      if (wr_hit && !bank_sel_reg)
        mem_b[wr_beat] <= wr_coef;
      rd_a_reg <= mem_a[cnt_reg];
      rd_b_reg <= mem_b[cnt_reg];
    end

    assign coef_sel = unity1_reg ? COEF_UNITY : (use_b1_reg ? rd_b_reg : rd_a_reg);

    cmult_rnd_sat #(
      .NBW_IN  (NBW_IN),
      .NBI_IN  (NBI_IN),
      .NBW_OUT (NBW_OUT),
      .NBI_OUT (NBI_OUT)
    ) u_cmult (
      .clk         (clk),
      .rst_async_n (rst_async_n),
      .a_re        (d_i1_reg[gi*NBW_IN +: NBW_IN]),
      .a_im        (d_q1_reg[gi*NBW_IN +: NBW_IN]),
      .c_re        (coef_sel.re),
      .c_im        (coef_sel.im),
      .y_re        (o_data_i[gi*NBW_OUT +: NBW_OUT]),
      .y_im        (o_data_q[gi*NBW_OUT +: NBW_OUT])
    );
  end

endmodule

// File: tb/tb_fd_eq512_coef_mult.sv
// Directed bench for fd_eq512_coef_mult: every lane gets the same bin value, and each
// output beat is checked on lane 0 plus a lane-uniformity flag against hand-worked values.
module tb_fd_eq512_coef_mult;

  localparam int NBW = 11;
  localparam int NS  = 64;

  logic             clk = 1'b0;
  logic             rst_async_n;
  logic             i_valid;
  logic [NS*NBW-1:0] i_data_i, i_data_q;
  logic             i_bypass;
  logic             i_cfg_we;
  logic [8:0]       i_cfg_addr;
  logic [9:0]       i_cfg_coef_i, i_cfg_coef_q;
  logic             i_cfg_commit;
  logic             o_cfg_busy, o_coef_loaded, o_valid;
  logic [2:0]       o_beat;
  logic [NS*NBW-1:0] o_data_i, o_data_q;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    int beat;
    int re0;
    int im0;
    int re63;
    int im63;
    bit uni;
    int cyc;
  } obs_t;
  obs_t obs_q[$];

  fd_eq512_coef_mult dut (
    .clk           (clk),
    .rst_async_n   (rst_async_n),
    .i_valid       (i_valid),
    .i_data_i      (i_data_i),
    .i_data_q      (i_data_q),
    .i_bypass      (i_bypass),
    .i_cfg_we      (i_cfg_we),
    .i_cfg_addr    (i_cfg_addr),
    .i_cfg_coef_i  (i_cfg_coef_i),
    .i_cfg_coef_q  (i_cfg_coef_q),
    .i_cfg_commit  (i_cfg_commit),
    .o_cfg_busy    (o_cfg_busy),
    .o_coef_loaded (o_coef_loaded),
    .o_valid       (o_valid),
    .o_beat        (o_beat),
    .o_data_i      (o_data_i),
    .o_data_q      (o_data_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      obs_t o;
      o.beat = int'(o_beat);
      o.re0  = int'($signed(o_data_i[NBW-1:0]));
      o.im0  = int'($signed(o_data_q[NBW-1:0]));
      o.re63 = int'($signed(o_data_i[63*NBW +: NBW]));
      o.im63 = int'($signed(o_data_q[63*NBW +: NBW]));
      o.uni  = 1'b1;
      for (int l = 1; l < NS; l++)
        if (o_data_i[l*NBW +: NBW] !== o_data_i[NBW-1:0] ||
            o_data_q[l*NBW +: NBW] !== o_data_q[NBW-1:0])
          o.uni = 1'b0;
      o.cyc = cyc;
      obs_q.push_back(o);
      $display("out beat=%0d lane0=(%0d,%0d) lane63=(%0d,%0d) uniform=%0d",
               o.beat, o.re0, o.im0, o.re63, o.im63, o.uni);
    end
  end

  task automatic drive(input logic v, input int re, input int im);
    i_valid = v;
    for (int l = 0; l < NS; l++) begin
      i_data_i[l*NBW +: NBW] = 11'(re);
      i_data_q[l*NBW +: NBW] = 11'(im);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) drive(1'b0, 0, 0);
  endtask

  task automatic cfg_write(input int addr, input int ci, input int cq);
    i_cfg_we     = 1'b1;
    i_cfg_addr   = 9'(addr);
    i_cfg_coef_i = 10'(ci);
    i_cfg_coef_q = 10'(cq);
    @(negedge clk);
    i_cfg_we     = 1'b0;
  endtask

  // beats 0..3 get the "lo" coefficient, beats 4..7 the "hi" one
  task automatic cfg_fill(input int ci_lo, input int cq_lo, input int ci_hi, input int cq_hi);
    for (int a = 0; a < 512; a++) begin
      i_cfg_we     = 1'b1;
      i_cfg_addr   = 9'(a);
      i_cfg_coef_i = (a < 256) ? 10'(ci_lo) : 10'(ci_hi);
      i_cfg_coef_q = (a < 256) ? 10'(cq_lo) : 10'(cq_hi);
      @(negedge clk);
    end
    i_cfg_we = 1'b0;
  endtask

  task automatic commit();
    i_cfg_commit = 1'b1;
    @(negedge clk);
    i_cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    rst_async_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b0 || o_beat !== 3'd0) $display("FAIL reset_valid_beat got v=%0b beat=%0d want v=0 beat=0", o_valid, o_beat);
    else n_pass++;
    n_checks++;
    if (o_data_i !== '0 || o_data_q !== '0) $display("FAIL reset_data got nonzero want 0");
    else n_pass++;
    n_checks++;
    if (o_cfg_busy !== 1'b0 || o_coef_loaded !== 1'b0) $display("FAIL reset_cfg got busy=%0b loaded=%0b want 0 0", o_cfg_busy, o_coef_loaded);
    else n_pass++;
    rst_async_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unity();
    int t0;
    obs_q.delete();
    t0 = cyc;
    for (int k = 0; k < 8; k++) drive(1'b1, 100, 0);
    drain();
    n_checks++;
    if (obs_q.size() !== 8) $display("FAIL unity_count got %0d want 8", obs_q.size());
    else n_pass++;
    if (obs_q.size() > 0) begin
      n_checks++;
      if (obs_q[0].cyc - t0 !== 3) $display("FAIL unity_latency got %0d want 3", obs_q[0].cyc - t0);
      else n_pass++;
    end
    for (int k = 0; k < obs_q.size() && k < 8; k++) begin
      n_checks++;
      if (obs_q[k].beat !== k || obs_q[k].re0 !== 100 || obs_q[k].im0 !== 0 || !obs_q[k].uni)
        $display("FAIL unity_beat%0d got beat=%0d (%0d,%0d) uni=%0d want beat=%0d (100,0) uni=1",
                 k, obs_q[k].beat, obs_q[k].re0, obs_q[k].im0, obs_q[k].uni, k);
      else n_pass++;
    end
  endtask

  task automatic test_round();
    int di[8] = '{3, 100, 1, -100, 0, 1023, 5, -5};
    int dq[8] = '{-3, 50, -1, -50, 0, -1023, 7, -7};
    int er[8] = '{2, 50, 1, -50, 0, 512, 3, -2};
    int ei[8] = '{-1, 25, 0, -25, 0, -511, 4, -3};
    cfg_fill(128, 0, 128, 0);
    commit();
    n_checks++;
    if (o_cfg_busy !== 1'b1 || o_coef_loaded !== 1'b0) $display("FAIL round_pending got busy=%0b loaded=%0b want 1 0", o_cfg_busy, o_coef_loaded);
    else n_pass++;
    obs_q.delete();
    for (int k = 0; k < 8; k++) drive(1'b1, di[k], dq[k]);
    drain();
    n_checks++;
    if (o_cfg_busy !== 1'b0 || o_coef_loaded !== 1'b1) $display("FAIL round_swapped got busy=%0b loaded=%0b want 0 1", o_cfg_busy, o_coef_loaded);
    else n_pass++;
    n_checks++;
    if (obs_q.size() !== 8) $display("FAIL round_count got %0d want 8", obs_q.size());
    else n_pass++;
    for (int k = 0; k < obs_q.size() && k < 8; k++) begin
      n_checks++;
      if (obs_q[k].beat !== k || obs_q[k].re0 !== er[k] || obs_q[k].im0 !== ei[k] || !obs_q[k].uni)
        $display("FAIL round_beat%0d got beat=%0d (%0d,%0d) uni=%0d want beat=%0d (%0d,%0d) uni=1",
                 k, obs_q[k].beat, obs_q[k].re0, obs_q[k].im0, obs_q[k].uni, k, er[k], ei[k]);
      else n_pass++;
    end
  endtask

  task automatic test_saturate();
    int di[8] = '{1023, 1023, 1023, -1024, 1023, 1023, 1023, -1024};
    int dq[8] = '{-1023, -1023, 0, 0, -1023, -1023, 0, 0};
    int er[8] = '{1023, 1023, 1023, -1023, -1023, -1023, -1023, 1023};
    int ei[8] = '{-1023, -1023, 0, 0, 1023, 1023, 0, 0};
    cfg_fill(384, 0, -384, 0);
    commit();
    obs_q.delete();
    for (int k = 0; k < 8; k++) drive(1'b1, di[k], dq[k]);
    drain();
    n_checks++;
    if (obs_q.size() !== 8) $display("FAIL sat_count got %0d want 8", obs_q.size());
    else n_pass++;
    for (int k = 0; k < obs_q.size() && k < 8; k++) begin
      n_checks++;
      if (obs_q[k].beat !== k || obs_q[k].re0 !== er[k] || obs_q[k].im0 !== ei[k] || !obs_q[k].uni)
        $display("FAIL sat_beat%0d got beat=%0d (%0d,%0d) uni=%0d want beat=%0d (%0d,%0d) uni=1",
                 k, obs_q[k].beat, obs_q[k].re0, obs_q[k].im0, obs_q[k].uni, k, er[k], ei[k]);
      else n_pass++;
    end
  endtask

  task automatic test_midframe_commit();
    cfg_fill(128, 0, 128, 0);
    commit();
    obs_q.delete();
    for (int k = 0; k < 8; k++) drive(1'b1, 100, 0);
    drain();
    for (int k = 0; k < obs_q.size(); k++) begin
      n_checks++;
      if (obs_q[k].re0 !== 50 || obs_q[k].im0 !== 0) $display("FAIL mid_setup%0d got (%0d,%0d) want (50,0)", k, obs_q[k].re0, obs_q[k].im0);
      else n_pass++;
    end
    cfg_fill(0, 256, 0, 256);
    obs_q.delete();
    for (int k = 0; k < 16; k++) begin
      i_cfg_commit = (k == 3);
      drive(1'b1, 7, 0);
      i_cfg_commit = 1'b0;
      if (k == 3) begin
        n_checks++;
        if (o_cfg_busy !== 1'b1) $display("FAIL mid_busy got %0b want 1", o_cfg_busy);
        else n_pass++;
      end
    end
    drain();
    n_checks++;
    if (obs_q.size() !== 16) $display("FAIL mid_count got %0d want 16", obs_q.size());
    else n_pass++;
    for (int k = 0; k < obs_q.size() && k < 16; k++) begin
      int wr = (k < 8) ? 4 : 0;
      int wi = (k < 8) ? 0 : 7;
      n_checks++;
      if (obs_q[k].beat !== (k % 8) || obs_q[k].re0 !== wr || obs_q[k].im0 !== wi || !obs_q[k].uni)
        $display("FAIL mid_beat%0d got beat=%0d (%0d,%0d) uni=%0d want beat=%0d (%0d,%0d) uni=1",
                 k, obs_q[k].beat, obs_q[k].re0, obs_q[k].im0, obs_q[k].uni, k % 8, wr, wi);
      else n_pass++;
    end
  endtask

  task automatic test_busy_write();
    // active bank holds j1.0, shadow holds 0.5
    commit();
    cfg_write(0, -256, 0);
    obs_q.delete();
    for (int k = 0; k < 8; k++) drive(1'b1, 7, 0);
    drain();
    n_checks++;
    if (obs_q.size() !== 8) $display("FAIL drop_count got %0d want 8", obs_q.size());
    else n_pass++;
    for (int k = 0; k < obs_q.size() && k < 8; k++) begin
      n_checks++;
      if (obs_q[k].re0 !== 4 || obs_q[k].im0 !== 0 || !obs_q[k].uni)
        $display("FAIL drop_beat%0d got (%0d,%0d) uni=%0d want (4,0) uni=1", k, obs_q[k].re0, obs_q[k].im0, obs_q[k].uni);
      else n_pass++;
    end
    i_cfg_we     = 1'b1;
    i_cfg_addr   = 9'd0;
    i_cfg_coef_i = 10'(-256);
    i_cfg_coef_q = 10'd0;
    i_cfg_commit = 1'b1;
    @(negedge clk);
    i_cfg_we     = 1'b0;
    i_cfg_commit = 1'b0;
    n_checks++;
    if (o_cfg_busy !== 1'b1) $display("FAIL keep_busy got %0b want 1", o_cfg_busy);
    else n_pass++;
    obs_q.delete();
    for (int k = 0; k < 8; k++) drive(1'b1, 7, 0);
    drain();
    n_checks++;
    if (obs_q.size() !== 8) $display("FAIL keep_count got %0d want 8", obs_q.size());
    else n_pass++;
    if (obs_q.size() > 0) begin
      n_checks++;
      if (obs_q[0].re0 !== -7 || obs_q[0].im0 !== 0 || obs_q[0].re63 !== 0 || obs_q[0].im63 !== 7)
        $display("FAIL keep_beat0 got lane0=(%0d,%0d) lane63=(%0d,%0d) want lane0=(-7,0) lane63=(0,7)",
                 obs_q[0].re0, obs_q[0].im0, obs_q[0].re63, obs_q[0].im63);
      else n_pass++;
    end
    for (int k = 1; k < obs_q.size() && k < 8; k++) begin
      n_checks++;
      if (obs_q[k].re0 !== 0 || obs_q[k].im0 !== 7 || !obs_q[k].uni)
        $display("FAIL keep_beat%0d got (%0d,%0d) uni=%0d want (0,7) uni=1", k, obs_q[k].re0, obs_q[k].im0, obs_q[k].uni);
      else n_pass++;
    end
  endtask

  task automatic test_gap_reset();
    i_bypass = 1'b1;
    obs_q.delete();
    for (int k = 0; k < 5; k++) drive(1'b1, 100, 0);
    drive(1'b0, 0, 0);
    drive(1'b0, 0, 0);
    for (int k = 5; k < 8; k++) drive(1'b1, 100, 0);
    drain();
    i_bypass = 1'b0;
    n_checks++;
    if (obs_q.size() !== 8) $display("FAIL gap_count got %0d want 8", obs_q.size());
    else n_pass++;
    for (int k = 0; k < obs_q.size() && k < 8; k++) begin
      n_checks++;
      if (obs_q[k].beat !== k || obs_q[k].re0 !== 100 || obs_q[k].im0 !== 0 || !obs_q[k].uni)
        $display("FAIL gap_beat%0d got beat=%0d (%0d,%0d) uni=%0d want beat=%0d (100,0) uni=1",
                 k, obs_q[k].beat, obs_q[k].re0, obs_q[k].im0, obs_q[k].uni, k);
      else n_pass++;
    end
    i_cfg_commit = 1'b1;
    drive(1'b1, 50, 0);
    i_cfg_commit = 1'b0;
    drive(1'b1, 50, 0);
    drive(1'b1, 50, 0);
    n_checks++;
    if (o_valid !== 1'b1 || o_cfg_busy !== 1'b1) $display("FAIL rst_pre got v=%0b busy=%0b want 1 1", o_valid, o_cfg_busy);
    else n_pass++;
    #1;
    rst_async_n = 1'b0;
    i_valid     = 1'b0;
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || o_cfg_busy !== 1'b0 || o_coef_loaded !== 1'b0)
      $display("FAIL rst_async got v=%0b busy=%0b loaded=%0b want 0 0 0", o_valid, o_cfg_busy, o_coef_loaded);
    else n_pass++;
    @(negedge clk);
    rst_async_n = 1'b1;
    obs_q.delete();
    for (int k = 0; k < 8; k++) drive(1'b1, 100, 0);
    drain();
    n_checks++;
    if (obs_q.size() !== 8 || o_coef_loaded !== 1'b0)
      $display("FAIL rst_after got count=%0d loaded=%0b want 8 0", obs_q.size(), o_coef_loaded);
    else n_pass++;
    for (int k = 0; k < obs_q.size() && k < 8; k++) begin
      n_checks++;
      if (obs_q[k].beat !== k || obs_q[k].re0 !== 100 || obs_q[k].im0 !== 0 || !obs_q[k].uni)
        $display("FAIL rst_beat%0d got beat=%0d (%0d,%0d) uni=%0d want beat=%0d (100,0) uni=1",
                 k, obs_q[k].beat, obs_q[k].re0, obs_q[k].im0, obs_q[k].uni, k);
      else n_pass++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_async_n  = 1'b0;
    i_valid      = 1'b0;
    i_data_i     = '0;
    i_data_q     = '0;
    i_bypass     = 1'b0;
    i_cfg_we     = 1'b0;
    i_cfg_addr   = '0;
    i_cfg_coef_i = '0;
    i_cfg_coef_q = '0;
    i_cfg_commit = 1'b0;
    test_reset();
    test_unity();
    test_round();
    test_saturate();
    test_midframe_commit();
    test_busy_write();
    test_gap_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
